sdio_data_block_ctrl: RTL and testbench

- Block sequencer directly upstream of the SDIO data PHY.
- Splits a CMD53 transfer (byte or block mode) into per-block PHY activations and drives PHY activate, direction and byte count.
- Buffers bytes between the PHY byte strobes and the function-side FIFO interface, and collects the CRC status for each block.

---
 rtl/sdio_data_block_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_sdio_data_block_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_data_block_ctrl.sv
// SDIO data block sequencer: splits CMD53 transfers into per-block PHY activations and
// buffers bytes between the PHY strobes and the function FIFO. Watchdog: SDIO_DATA_TIMEOUT_EN.
module sdio_data_block_ctrl #(
    parameter int ADDR_WIDTH     = 9,
    parameter int FIFO_DEPTH     = 512,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_xfer_start,
    input  logic        i_xfer_write,
    input  logic        i_block_mode,
    input  logic [12:0] i_block_size,
    input  logic [8:0]  i_block_count,
    input  logic [12:0] i_byte_count,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_xfer_done,
    output logic        o_crc_err,
    output logic        o_overflow,
    output logic [8:0]  o_blocks_done,
    output logic        o_fn_wr_stb,
    output logic [7:0]  o_fn_wr_data,
    input  logic        i_fn_wr_rdy,
    input  logic        i_fn_rd_valid,
    input  logic [7:0]  i_fn_rd_data,
    output logic        o_fn_rd_ack,
    output logic        o_phy_activate,
    output logic        o_phy_write_flag,
    output logic [12:0] o_phy_data_count,
    input  logic        i_phy_finished,
    input  logic        i_phy_wr_stb,
    input  logic [7:0]  i_phy_wr_data,
    output logic        o_phy_rd_stb,
    output logic [7:0]  o_phy_rd_data,
    input  logic        i_phy_hst_rdy,
    output logic        o_phy_com_rdy,
    input  logic        i_phy_crc_good
);
    localparam int PW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, LOAD, ACTIVE, WAIT_FIN, GAP, DONE} state_t;
    state_t state, state_nx;

    logic          write_q, block_mode_q, gap_cnt;
    logic [12:0]   len_q, stream_cnt;
    logic [8:0]    count_q;
    logic [PW-1:0] wr_ptr, rd_ptr, fill;
    logic [7:0]    mem [0:(1<<ADDR_WIDTH)-1];
    logic [13:0]   free_space;
    logic          full, empty, enough_data, enough_space, in_flight;
    logic          push_req, push, pop, drain;
    logic          stream_start, stream_next, stream_end;
    logic          block_go, done_go, finish, timeout, gap_stop;
    logic [7:0]    push_data;

    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign free_space   = 14'(FIFO_DEPTH) - 14'(fill);
    assign enough_data  = 14'(fill) >= {1'b0, len_q};
    assign enough_space = free_space >= {1'b0, len_q};
    assign in_flight    = (state == ACTIVE) || (state == WAIT_FIN);

    assign o_busy       = (state != IDLE);
    assign o_fn_rd_ack  = (state == LOAD) && !write_q && !i_abort && i_fn_rd_valid &&
                          !full && !enough_data;
    assign drain        = (state != IDLE) && write_q && !empty && i_fn_wr_rdy;
    assign stream_start = (state == ACTIVE) && !write_q && o_phy_com_rdy && i_phy_hst_rdy &&
                          !o_phy_rd_stb;
    assign stream_next  = o_phy_rd_stb && (stream_cnt != 13'd0);
    assign stream_end   = o_phy_rd_stb && (stream_cnt == 13'd0);
    assign push_req     = write_q ? (i_phy_wr_stb && in_flight) : o_fn_rd_ack;
    assign push         = push_req && !full;
    assign push_data    = write_q ? i_phy_wr_data : i_fn_rd_data;
    assign pop          = drain || stream_start || stream_next;
    assign finish       = (state == WAIT_FIN) && i_phy_finished;
    assign gap_stop     = o_crc_err || i_abort || !block_mode_q ||
                          ((count_q != 9'd0) && (o_blocks_done == count_q));

`ifdef SDIO_DATA_TIMEOUT_EN
    logic [16:0] tmo_cnt;

    // Restarted at every block activation, so each block gets the full budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 17'd0;
        end else if (block_go) begin
            tmo_cnt <= 17'd0;
        end else if (in_flight) begin
            tmo_cnt <= tmo_cnt + 17'd1;
        end
    end

    assign timeout = in_flight && (tmo_cnt >= 17'(TIMEOUT_CYCLES - 1)) && !i_phy_finished;
`else
    // Watchdog compiled out; the parameter only keeps the interface identical.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        block_go = 1'b0;
        done_go  = 1'b0;
        case (state)
            IDLE:     if (i_xfer_start) state_nx = LOAD;
            LOAD: begin
                if (i_abort) begin
                    state_nx = DONE;
                end else if (write_q ? enough_space : enough_data) begin
                    state_nx = ACTIVE;
                    block_go = 1'b1;
                end
            end
            ACTIVE: begin
                if (timeout)                  state_nx = DONE;
                else if (write_q || stream_end) state_nx = WAIT_FIN;
            end
            WAIT_FIN: begin
                if (timeout)             state_nx = DONE;
                else if (i_phy_finished) state_nx = GAP;
            end
            GAP:      if (gap_cnt) state_nx = gap_stop ? DONE : LOAD;
            DONE: begin
                if (!write_q || empty) begin
                    state_nx = IDLE;
                    done_go  = 1'b1;
                end
            end
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q          <= 1'b0;
            block_mode_q     <= 1'b0;
            len_q            <= 13'd0;
            count_q          <= 9'd0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            fill             <= '0;
            gap_cnt          <= 1'b0;
            stream_cnt       <= 13'd0;
            o_xfer_done      <= 1'b0;
            o_crc_err        <= 1'b0;
            o_overflow       <= 1'b0;
            o_blocks_done    <= 9'd0;
            o_fn_wr_stb      <= 1'b0;
            o_fn_wr_data     <= 8'h00;
            o_phy_activate   <= 1'b0;
            o_phy_write_flag <= 1'b0;
            o_phy_data_count <= 13'd0;
            o_phy_rd_stb     <= 1'b0;
            o_phy_rd_data    <= 8'hFF;
            o_phy_com_rdy    <= 1'b0;
        end else begin
            o_xfer_done <= done_go;
            gap_cnt     <= (state == GAP) ? !gap_cnt : 1'b0;

            if ((state == IDLE) && i_xfer_start) begin
                write_q       <= i_xfer_write;
                block_mode_q  <= i_block_mode;
                count_q       <= i_block_count;
                len_q         <= i_block_mode ? i_block_size :
                                 ((i_byte_count == 13'd0) ? 13'd512 : i_byte_count);
                o_crc_err     <= 1'b0;
                o_overflow    <= 1'b0;
                o_blocks_done <= 9'd0;
            end

            // Read leftovers are discarded at the end so the next transfer starts empty.
            if (done_go && !write_q) begin
                rd_ptr <= wr_ptr;
                fill   <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)      fill <= fill + PW'(1);
                else if (!push && pop) fill <= fill - PW'(1);
            end

            if (write_q && push_req && full) o_overflow <= 1'b1;

            o_fn_wr_stb <= drain;
            if (drain) o_fn_wr_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];

            if (block_go) begin
                o_phy_activate   <= 1'b1;
                o_phy_write_flag <= write_q;
                o_phy_data_count <= len_q;
                if (!write_q) o_phy_com_rdy <= 1'b1;
            end else if (finish || timeout || ((state == LOAD) && i_abort)) begin
                o_phy_activate <= 1'b0;
            end

            if (finish) begin
                o_blocks_done <= o_blocks_done + 9'd1;
                if (!i_phy_crc_good) o_crc_err <= 1'b1;
            end
            if (timeout) o_crc_err <= 1'b1;

            // Read stream: exactly len_q back-to-back strobes, head byte registered with each.
            if (timeout) begin
                o_phy_rd_stb  <= 1'b0;
                o_phy_com_rdy <= 1'b0;
            end else if (stream_start || stream_next) begin
                o_phy_rd_stb  <= 1'b1;
                o_phy_rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                stream_cnt    <= stream_start ? (len_q - 13'd1) : (stream_cnt - 13'd1);
            end else begin
                o_phy_rd_stb <= 1'b0;
                if (stream_end) o_phy_com_rdy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sdio_data_block_ctrl.sv
// Directed bench for sdio_data_block_ctrl (16-byte buffer, 100-cycle watchdog when enabled).
module tb_sdio_data_block_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_xfer_start = 0, i_xfer_write = 0, i_block_mode = 0, i_abort = 0;
    logic [12:0] i_block_size = 0, i_byte_count = 0;
    logic [8:0]  i_block_count = 0;
    logic        o_busy, o_xfer_done, o_crc_err, o_overflow;
    logic [8:0]  o_blocks_done;
    logic        o_fn_wr_stb, o_fn_rd_ack;
    logic [7:0]  o_fn_wr_data;
    logic        i_fn_wr_rdy = 0, i_fn_rd_valid = 0;
    logic [7:0]  i_fn_rd_data = 0;
    logic        o_phy_activate, o_phy_write_flag, o_phy_rd_stb, o_phy_com_rdy;
    logic [12:0] o_phy_data_count;
    logic [7:0]  o_phy_rd_data;
    logic        i_phy_finished = 0, i_phy_wr_stb = 0, i_phy_hst_rdy = 0, i_phy_crc_good = 1;
    logic [7:0]  i_phy_wr_data = 0;

    int checks = 0, errors = 0;
    int done_cnt = 0, act_cnt = 0, run = 0, low_run = 0, high_run = 0, min_gap = 1000;
    int fnq_at_act = 0, a0 = 0;
    logic act_prev = 1'b0, ack_now;
    logic [7:0] fn_src = 8'h00;
    logic [7:0] fn_q[$], phy_q[$];
    int run_q[$], dc_q[$], wf_q[$];

    sdio_data_block_ctrl #(.ADDR_WIDTH(4), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .i_xfer_start(i_xfer_start), .i_xfer_write(i_xfer_write),
        .i_block_mode(i_block_mode), .i_block_size(i_block_size), .i_block_count(i_block_count),
        .i_byte_count(i_byte_count), .i_abort(i_abort), .o_busy(o_busy),
        .o_xfer_done(o_xfer_done), .o_crc_err(o_crc_err), .o_overflow(o_overflow),
        .o_blocks_done(o_blocks_done), .o_fn_wr_stb(o_fn_wr_stb), .o_fn_wr_data(o_fn_wr_data),
        .i_fn_wr_rdy(i_fn_wr_rdy), .i_fn_rd_valid(i_fn_rd_valid), .i_fn_rd_data(i_fn_rd_data),
        .o_fn_rd_ack(o_fn_rd_ack), .o_phy_activate(o_phy_activate),
        .o_phy_write_flag(o_phy_write_flag), .o_phy_data_count(o_phy_data_count),
        .i_phy_finished(i_phy_finished), .i_phy_wr_stb(i_phy_wr_stb),
        .i_phy_wr_data(i_phy_wr_data), .o_phy_rd_stb(o_phy_rd_stb),
        .o_phy_rd_data(o_phy_rd_data), .i_phy_hst_rdy(i_phy_hst_rdy),
        .o_phy_com_rdy(o_phy_com_rdy), .i_phy_crc_good(i_phy_crc_good)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: acknowledged function bytes advance the source, outputs are logged.
    task automatic tick();
        #2;
        ack_now = o_fn_rd_ack;
        @(posedge clk);
        #1;
        if (ack_now === 1'b1) begin
            fn_src = fn_src + 8'd1;
            i_fn_rd_data = fn_src;
        end
        if (o_fn_wr_stb === 1'b1) fn_q.push_back(o_fn_wr_data);
        if (o_phy_rd_stb === 1'b1) begin
            phy_q.push_back(o_phy_rd_data);
            run++;
        end else if (run != 0) begin
            run_q.push_back(run);
            run = 0;
        end
        if (o_xfer_done === 1'b1) done_cnt++;
        if (o_phy_activate === 1'b1 && !act_prev) begin
            act_cnt++;
            dc_q.push_back(int'(o_phy_data_count));
            wf_q.push_back(int'(o_phy_write_flag));
            if (act_cnt > 1 && low_run < min_gap) min_gap = low_run;
            low_run = 0;
            fnq_at_act = fn_q.size();
        end
        if (o_phy_activate === 1'b1) high_run++;
        else low_run++;
        act_prev = (o_phy_activate === 1'b1);
    endtask

    task automatic start(input logic wr, input logic bm, input int bsize, input int bcnt,
                         input int bytes);
        i_xfer_write  = wr;
        i_block_mode  = bm;
        i_block_size  = 13'(bsize);
        i_block_count = 9'(bcnt);
        i_byte_count  = 13'(bytes);
        i_xfer_start  = 1'b1;
        tick();
        i_xfer_start  = 1'b0;
    endtask

    task automatic wait_act(input string tag, input int n);
        for (int i = 0; i < 300 && act_cnt < n; i++) tick();
        chk(tag, act_cnt, n);
    endtask

    task automatic wait_done(input string tag);
        int d0 = done_cnt;
        for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
        chk(tag, done_cnt - d0, 1);
    endtask

    task automatic wait_stream(input string tag, input int n);
        for (int i = 0; i < 300 && !(phy_q.size() == n && o_phy_rd_stb === 1'b0); i++) tick();
        chk(tag, phy_q.size(), n);
    endtask

    task automatic send_wr(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            i_phy_wr_stb  = 1'b1;
            i_phy_wr_data = base + 8'(i);
            tick();
        end
        i_phy_wr_stb = 1'b0;
    endtask

    task automatic phy_finish(input logic good);
        i_phy_finished = 1'b1;
        i_phy_crc_good = good;
        tick();
        i_phy_finished = 1'b0;
        i_phy_crc_good = 1'b1;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_activate", o_phy_activate, 0);
        chk("rst_rd_data", o_phy_rd_data, 8'hFF);
        chk("rst_blocks", o_blocks_done, 0);
        chk("rst_fn_stb", o_fn_wr_stb, 0);
        chk("rst_com_rdy", o_phy_com_rdy, 0);
        chk("rst_done", o_xfer_done, 0);
        rst_n = 1'b1;
        tick();

        // Byte-mode write of 4 bytes; inputs changed after start must be ignored
        i_fn_wr_rdy = 1'b1;
        start(1'b1, 1'b0, 0, 0, 4);
        i_byte_count = 13'd9;
        i_xfer_write = 1'b0;
        chk("t1_busy", o_busy, 1);
        wait_act("t1_act", 1);
        chk("t1_count", o_phy_data_count, 4);
        chk("t1_wflag", o_phy_write_flag, 1);
        i_phy_wr_stb = 1'b1; i_phy_wr_data = 8'hA5; tick();
        i_phy_wr_data = 8'h5A; tick();
        i_phy_wr_data = 8'h01; tick();
        i_phy_wr_data = 8'hFF; tick();
        i_phy_wr_stb = 1'b0;
        phy_finish(1'b1);
        chk("t1_act_low", o_phy_activate, 0);
        wait_done("t1_done");
        chk("t1_nbytes", fn_q.size(), 4);
        if (fn_q.size() == 4) begin
            chk("t1_b0", fn_q[0], 8'hA5);
            chk("t1_b1", fn_q[1], 8'h5A);
            chk("t1_b2", fn_q[2], 8'h01);
            chk("t1_b3", fn_q[3], 8'hFF);
        end
        chk("t1_blocks", o_blocks_done, 1);
        chk("t1_crc", o_crc_err, 0);
        chk("t1_idle", o_busy, 0);
        tick();
        chk("t1_done_pulse", o_xfer_done, 0);

        // Block read 3 x 16 from function bytes 0x00..0x2F
        fn_q.delete(); dc_q.delete(); wf_q.delete(); run_q.delete(); phy_q.delete();
        i_fn_wr_rdy = 1'b0;
        fn_src = 8'h00; i_fn_rd_data = 8'h00; i_fn_rd_valid = 1'b1; i_phy_hst_rdy = 1'b1;
        a0 = act_cnt;
        min_gap = 1000;
        start(1'b0, 1'b1, 16, 3, 0);
        for (int b = 1; b <= 3; b++) begin
            wait_act($sformatf("t2_act%0d", b), a0 + b);
            chk($sformatf("t2_comrdy%0d", b), o_phy_com_rdy, 1);
            wait_stream($sformatf("t2_stream%0d", b), 16 * b);
            chk($sformatf("t2_comrdy_off%0d", b), o_phy_com_rdy, 0);
            phy_finish(1'b1);
        end
        wait_done("t2_done");
        i_fn_rd_valid = 1'b0;
        chk("t2_nact", act_cnt - a0, 3);
        chk("t2_blocks", o_blocks_done, 3);
        chk("t2_gap", int'(min_gap >= 2), 1);
        chk("t2_nruns", run_q.size(), 3);
        foreach (run_q[i]) chk($sformatf("t2_run%0d", i), run_q[i], 16);
        foreach (dc_q[i]) chk($sformatf("t2_dcount%0d", i), dc_q[i], 16);
        foreach (wf_q[i]) chk($sformatf("t2_wflag%0d", i), wf_q[i], 0);
        if (phy_q.size() == 48)
            foreach (phy_q[i]) chk($sformatf("t2_data%0d", i), phy_q[i], i);

        // Block write, CRC bad on block 1: no second activation
        i_fn_wr_rdy = 1'b1;
        a0 = act_cnt;
        start(1'b1, 1'b1, 4, 2, 0);
        wait_act("t3_act", a0 + 1);
        send_wr(4, 8'h30);
        phy_finish(1'b0);
        wait_done("t3_done");
        chk("t3_crc", o_crc_err, 1);
        chk("t3_nact", act_cnt - a0, 1);
        chk("t3_blocks", o_blocks_done, 1);

        // Unbounded read of 8-byte blocks, abort during block 2
        phy_q.delete(); run_q.delete();
        fn_src = 8'h40; i_fn_rd_data = 8'h40; i_fn_rd_valid = 1'b1;
        a0 = act_cnt;
        start(1'b0, 1'b1, 8, 0, 0);
        chk("t4_crc_cleared", o_crc_err, 0);
        chk("t4_blocks_cleared", o_blocks_done, 0);
        wait_act("t4_act1", a0 + 1);
        wait_stream("t4_stream1", 8);
        phy_finish(1'b1);
        wait_act("t4_act2", a0 + 2);
        tick(); tick(); tick();
        i_abort = 1'b1;
        wait_stream("t4_stream2", 16);
        phy_finish(1'b1);
        wait_done("t4_done");
        i_abort = 1'b0;
        i_fn_rd_valid = 1'b0;
        chk("t4_blocks", o_blocks_done, 2);
        chk("t4_nact", act_cnt - a0, 2);
        if (phy_q.size() == 16)
            foreach (phy_q[i]) chk($sformatf("t4_data%0d", i), phy_q[i], 8'h40 + 8'(i));

        // Write with the function stalled: 17th byte dropped, next block waits for space
        fn_q.delete();
        i_fn_wr_rdy = 1'b0;
        a0 = act_cnt;
        start(1'b1, 1'b1, 16, 2, 0);
        wait_act("t5_act1", a0 + 1);
        send_wr(16, 8'h00);
        chk("t5_no_ovf_yet", o_overflow, 0);
        send_wr(1, 8'hEE);
        chk("t5_ovf", o_overflow, 1);
        phy_finish(1'b1);
        for (int i = 0; i < 10; i++) tick();
        chk("t5_stall_act", o_phy_activate, 0);
        chk("t5_stall_nact", act_cnt - a0, 1);
        chk("t5_stall_busy", o_busy, 1);
        i_fn_wr_rdy = 1'b1;
        wait_act("t5_act2", a0 + 2);
        chk("t5_space_at_act", fnq_at_act, 16);
        send_wr(16, 8'h80);
        phy_finish(1'b1);
        wait_done("t5_done");
        chk("t5_nbytes", fn_q.size(), 32);
        if (fn_q.size() == 32)
            foreach (fn_q[i]) chk($sformatf("t5_data%0d", i), fn_q[i],
                                  (i < 16) ? i : (8'h80 + i - 16));
        chk("t5_ovf_sticky", o_overflow, 1);
        chk("t5_blocks", o_blocks_done, 2);

        // Abort while LOAD waits on the function
        a0 = act_cnt;
        start(1'b0, 1'b1, 8, 1, 0);
        tick(); tick(); tick();
        chk("t6_loading", o_busy, 1);
        i_abort = 1'b1;
        wait_done("t6_done");
        i_abort = 1'b0;
        chk("t6_nact", act_cnt - a0, 0);
        chk("t6_blocks", o_blocks_done, 0);

        // PHY never finishes
        a0 = act_cnt;
        start(1'b1, 1'b1, 4, 1, 0);
        wait_act("t7_act", a0 + 1);
        high_run = 1;
`ifdef SDIO_DATA_TIMEOUT_EN
        wait_done("t7_tmo_done");
        chk("t7_tmo_high", high_run, 100);
        chk("t7_tmo_crc", o_crc_err, 1);
        chk("t7_tmo_act", o_phy_activate, 0);
`else
        for (int i = 0; i < 150; i++) tick();
        chk("t7_hold_act", o_phy_activate, 1);
        chk("t7_hold_busy", o_busy, 1);
        phy_finish(1'b1);
        wait_done("t7_done");
        chk("t7_crc", o_crc_err, 0);
`endif

        // Asynchronous reset in the middle of a read stream
        phy_q.delete();
        fn_src = 8'h10; i_fn_rd_data = 8'h10; i_fn_rd_valid = 1'b1;
        a0 = act_cnt;
        start(1'b0, 1'b1, 8, 1, 0);
        wait_act("t8_act", a0 + 1);
        tick(); tick(); tick();
        chk("t8_streaming", o_phy_rd_stb, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t8_rst_act", o_phy_activate, 0);
        chk("t8_rst_stb", o_phy_rd_stb, 0);
        chk("t8_rst_data", o_phy_rd_data, 8'hFF);
        chk("t8_rst_comrdy", o_phy_com_rdy, 0);
        chk("t8_rst_busy", o_busy, 0);
        chk("t8_rst_ack", o_fn_rd_ack, 0);
        chk("t8_rst_blocks", o_blocks_done, 0);
        i_fn_rd_valid = 1'b0;
        i_phy_hst_rdy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t8_post_busy", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
